mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction-fetch stage and the memory (load/store) stage of the pipelined CPU. Both requesters share one synchronous block RAM with a one-cycle read latency. Each cycle the arbiter grants at most one request, drives the RAM port, and routes the read data back to the owner one cycle later. It also enforces fetch-starvation protection and drops stale fetch responses on a branch flush.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/starve_counter.sv | 26 ++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/memory-stage RAM arbiter.
package mem_arbiter_pkg;
  localparam int STARVE_MAX_DEF = 3;

  typedef logic [15:0] addr;
  typedef logic [31:0] block;
  typedef logic [31:0] inst;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_t;
endpackage

// File: rtl/starve_counter.sv
// Saturating 4-bit counter of consecutive data grants taken while fetch waits.
module starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == MAX_V);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data has priority, fetch is forced through after
// STARVE_MAX back-to-back data grants; read data returns one cycle after grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic       starve_sat;
  logic       flush_q;
  mem_owner_t owner_q;
  mem_owner_t owner_d;

  // Stage 0: arbitration and RAM port mux
  assign if_gnt = ~rst & if_req & (~d_req | starve_sat);
  assign d_gnt  = ~rst & d_req & ~(if_req & starve_sat);

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (d_gnt & if_req),
    .clr (if_gnt | ~if_req),
    .sat (starve_sat)
  );

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // Stage 1: response owner and flush history
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      flush_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      flush_q <= if_flush;
    end
  end

  // rst gating drops a response whose grant happened just before reset rose
  assign if_rvalid = ~rst & (owner_q == OWN_IF) & ~(if_flush | flush_q);
  assign d_rvalid  = ~rst & (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int SMAX   = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_flush;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM driven by the DUT's port; reference memory tracks what the rules say was written
  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  assign mem_rdata = rdata_r;

  int          passed = 0;
  int          total  = 0;
  int          wait_n;
  int          pend;          // 0 none, 1 fetch, 2 data
  logic [DATA_W-1:0] pend_data;
  bit          flush_prev;
  bit          e_if, e_d, last_if_gnt, last_d_gnt;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: inputs already driven at negedge; check, then advance model and RAM
  task automatic step();
    bit e_if_rv, e_d_rv;
    logic              s_en, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    #1;
    if (rst) begin
      e_if = 1'b0;
      e_d  = 1'b0;
    end else begin
      e_if = if_req && (!d_req || wait_n == SMAX);
      e_d  = d_req && !e_if;
    end
    e_if_rv = !rst && pend == 1 && !if_flush && !flush_prev;
    e_d_rv  = !rst && pend == 2;

    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("d_gnt", 32'(d_gnt), 32'(e_d));
    check("one_gnt", 32'(if_gnt & d_gnt), 32'd0);
    check("mem_en", 32'(mem_en), 32'(e_if | e_d));
    check("mem_we", 32'(mem_we), 32'(e_d & d_we));
    if (e_if) check("mem_addr_if", 32'(mem_addr), 32'(if_addr));
    if (e_d) check("mem_addr_d", 32'(mem_addr), 32'(d_addr));
    if (e_d && d_we) check("mem_wdata", mem_wdata, d_wdata);
    check("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    check("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
    if (e_if_rv) check("if_rdata", if_rdata, pend_data);
    if (e_d_rv) check("d_rdata", d_rdata, pend_data);

    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    if (s_en) begin
      if (s_we) ram[s_addr] = s_wdata;
      else rdata_r = ram[s_addr];
    end

    if (rst) begin
      wait_n = 0; pend = 0; flush_prev = 1'b0;
    end else begin
      flush_prev = if_flush;
      if (e_if) begin
        pend = 1; pend_data = ref_mem[if_addr];
      end else if (e_d && !d_we) begin
        pend = 2; pend_data = ref_mem[d_addr];
      end else begin
        pend = 0;
      end
      if (e_d && d_we) ref_mem[d_addr] = d_wdata;
      if (e_if || !if_req) wait_n = 0;
      else if (e_d) wait_n = (wait_n + 1 > SMAX) ? SMAX : wait_n + 1;
    end
    last_if_gnt = e_if;
    last_d_gnt  = e_d;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DATA_W'(32'h100 + i);
      ref_mem[i] = DATA_W'(32'h100 + i);
    end
    rdata_r = '0;
    wait_n = 0; pend = 0; pend_data = '0; flush_prev = 1'b0;
    last_if_gnt = 1'b0; last_d_gnt = 1'b0;
    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0004; if_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0008; d_wdata = '0;
    @(negedge clk);

    // Reset held with both requesting, then release: data wins first
    repeat (3) step();
    rst = 1'b0;
    step();
    check("post_rst_d_gnt", 32'(last_d_gnt), 32'd1);
    d_req = 1'b0; if_req = 1'b0;
    step();

    // Fetch-only streaming
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = ADDR_W'(i);
      step();
    end
    if_req = 1'b0;
    step();

    // Store then load of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'hDEADBEEF;
    step();
    d_we = 1'b0; d_wdata = '0;
    step();
    d_req = 1'b0;
    step();
    check("load_back", ref_mem[16'h0020], 32'hDEADBEEF);

    // Continuous contention: D,D,D,IF repeating
    for (int k = 0; k < 12; k++) begin
      if_req = 1'b1; if_addr = ADDR_W'(k);
      d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(16'h40 + k);
      step();
      check("starve_pattern", 32'(last_d_gnt), 32'((k % 4) != 3));
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Flush: fetches in N-1 and N, flush in N, fetch in N+1 delivered in N+2
    if_req = 1'b1; if_addr = 16'h0010; step();
    if_addr = 16'h0011; if_flush = 1'b1; step();
    if_addr = 16'h0012; if_flush = 1'b0; step();
    if_req = 1'b0; step();

    // Load granted in N-1, flush in N while both request: load still returns
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; step();
    if_req = 1'b1; if_addr = 16'h0030; if_flush = 1'b1; d_addr = 16'h0021; step();
    if_flush = 1'b0; step();
    step();
    step();
    if_req = 1'b0; d_req = 1'b0; step();

    // Read granted immediately before reset rises yields no response
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0005; step();
    d_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0; step();

    // Random traffic obeying the hold-until-grant handshake
    for (int n = 0; n < 400; n++) begin
      if (!if_req || last_if_gnt) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = ADDR_W'($urandom_range(0, 63));
      end
      if (!d_req || last_d_gnt) begin
        d_req   = ($urandom_range(0, 99) < 65);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = ADDR_W'($urandom_range(0, 63));
        d_wdata = DATA_W'($urandom);
      end
      if_flush = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
